// File: rtl/conv2_window_buf.sv
// conv2_window_buf
// Streaming KxK window generator for one conv2 input channel. Consumes the raster-scan pool1
// feature map (IMG_W x IMG_H signed pixels) and emits every fully-inside KxK window as K*K
// parallel taps, one window per valid_out_buf pulse.
//
// Ports:
//   clk                       rising-edge clock
//   rst_n                     asynchronous active-low reset
//   valid_in                  data_in carries a new pixel this cycle
//   data_in                   pixel, row-major raster order
//   data_out_0..data_out_24   window taps; tap r*K+c = pixel(row-(K-1)+r, col-(K-1)+c)
//   valid_out_buf             one-cycle pulse: taps hold a new complete window
//   frame_done                only when CONV2_WIN_FRAME_DONE_EN is defined; pulses with the
//                             last window of each frame
//
// Optional feature macro: CONV2_WIN_FRAME_DONE_EN (adds frame_done).
module conv2_window_buf #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int K      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [DATA_W-1:0] data_out_4,
  output logic [DATA_W-1:0] data_out_5,
  output logic [DATA_W-1:0] data_out_6,
  output logic [DATA_W-1:0] data_out_7,
  output logic [DATA_W-1:0] data_out_8,
  output logic [DATA_W-1:0] data_out_9,
  output logic [DATA_W-1:0] data_out_10,
  output logic [DATA_W-1:0] data_out_11,
  output logic [DATA_W-1:0] data_out_12,
  output logic [DATA_W-1:0] data_out_13,
  output logic [DATA_W-1:0] data_out_14,
  output logic [DATA_W-1:0] data_out_15,
  output logic [DATA_W-1:0] data_out_16,
  output logic [DATA_W-1:0] data_out_17,
  output logic [DATA_W-1:0] data_out_18,
  output logic [DATA_W-1:0] data_out_19,
  output logic [DATA_W-1:0] data_out_20,
  output logic [DATA_W-1:0] data_out_21,
  output logic [DATA_W-1:0] data_out_22,
  output logic [DATA_W-1:0] data_out_23,
  output logic [DATA_W-1:0] data_out_24,
  output logic              valid_out_buf
`ifdef CONV2_WIN_FRAME_DONE_EN
  ,
  output logic              frame_done
`endif
);

  localparam int ChainLen = (K - 1) * IMG_W + K;
  localparam int NTaps    = K * K;
  localparam int ColW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RowW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [0:0] {StFill, StRun} state_e;

  logic [DATA_W-1:0] chain_q [ChainLen];
  logic [DATA_W-1:0] taps_q  [NTaps];

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  state_e          state_q, state_d;
  logic            win_pend_q, win_pend_d;
  logic            valid_q;
  logic            col_last, row_last;

  assign col_last = (col_q == ColW'(IMG_W - 1));
  assign row_last = (row_q == RowW'(IMG_H - 1));

  // Next-state: counters, FILL/RUN, and the "window completed" flag.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    state_d    = state_q;
    win_pend_d = 1'b0;
    if (valid_in) begin
      // Windows ending at col < K-1 would straddle two rows and are skipped.
      win_pend_d = (state_q == StRun) && (col_q >= ColW'(K - 1));
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      unique case (state_q)
        StFill: if (col_last && (row_q == RowW'(K - 2))) state_d = StRun;
        StRun:  if (col_last && row_last)                state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      state_q    <= StFill;
      win_pend_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      state_q    <= state_d;
      win_pend_q <= win_pend_d;
      valid_q    <= win_pend_q;
    end
  end

  // Pixel chain; chain_q[0] is the newest pixel. Moves only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ChainLen; i++) chain_q[i] <= '0;
    end else if (valid_in) begin
      chain_q[0] <= data_in;
      for (int i = 1; i < ChainLen; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  // Taps load one clock after the completing pixel, reading the chain before any further shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTaps; i++) taps_q[i] <= '0;
    end else if (win_pend_q) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          taps_q[r*K+c] <= chain_q[(K-1-r)*IMG_W + (K-1-c)];
        end
      end
    end
  end

  assign valid_out_buf = valid_q;

`ifdef CONV2_WIN_FRAME_DONE_EN
  logic done_pend_q, frame_done_q;

  // The last pixel of a frame always completes a window, so this aligns with that pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      done_pend_q  <= valid_in && col_last && row_last;
      frame_done_q <= done_pend_q;
    end
  end

  assign frame_done = frame_done_q;
`endif

  assign data_out_0  = taps_q[0];
  assign data_out_1  = taps_q[1];
  assign data_out_2  = taps_q[2];
  assign data_out_3  = taps_q[3];
  assign data_out_4  = taps_q[4];
  assign data_out_5  = taps_q[5];
  assign data_out_6  = taps_q[6];
  assign data_out_7  = taps_q[7];
  assign data_out_8  = taps_q[8];
  assign data_out_9  = taps_q[9];
  assign data_out_10 = taps_q[10];
  assign data_out_11 = taps_q[11];
  assign data_out_12 = taps_q[12];
  assign data_out_13 = taps_q[13];
  assign data_out_14 = taps_q[14];
  assign data_out_15 = taps_q[15];
  assign data_out_16 = taps_q[16];
  assign data_out_17 = taps_q[17];
  assign data_out_18 = taps_q[18];
  assign data_out_19 = taps_q[19];
  assign data_out_20 = taps_q[20];
  assign data_out_21 = taps_q[21];
  assign data_out_22 = taps_q[22];
  assign data_out_23 = taps_q[23];
  assign data_out_24 = taps_q[24];

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed self-checking bench for conv2_window_buf (12x12 map, 5x5 windows).
module tb_conv2_window_buf;

  typedef logic [24:0][11:0] win_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [11:0] data_out_5, data_out_6, data_out_7, data_out_8, data_out_9;
  logic [11:0] data_out_10, data_out_11, data_out_12, data_out_13, data_out_14;
  logic [11:0] data_out_15, data_out_16, data_out_17, data_out_18, data_out_19;
  logic [11:0] data_out_20, data_out_21, data_out_22, data_out_23, data_out_24;
  logic        valid_out_buf;
`ifdef CONV2_WIN_FRAME_DONE_EN
  logic        frame_done;
`endif

  win_t taps, last_taps;
  assign taps = {data_out_24, data_out_23, data_out_22, data_out_21, data_out_20,
                 data_out_19, data_out_18, data_out_17, data_out_16, data_out_15,
                 data_out_14, data_out_13, data_out_12, data_out_11, data_out_10,
                 data_out_9, data_out_8, data_out_7, data_out_6, data_out_5,
                 data_out_4, data_out_3, data_out_2, data_out_1, data_out_0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_viol = 0;
  int acc52 = 0;
  win_t wins[$];
  int win_cyc[$];
  logic [11:0] fd_val[$];

  conv2_window_buf dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4), .data_out_5(data_out_5),
    .data_out_6(data_out_6), .data_out_7(data_out_7), .data_out_8(data_out_8),
    .data_out_9(data_out_9), .data_out_10(data_out_10), .data_out_11(data_out_11),
    .data_out_12(data_out_12), .data_out_13(data_out_13), .data_out_14(data_out_14),
    .data_out_15(data_out_15), .data_out_16(data_out_16), .data_out_17(data_out_17),
    .data_out_18(data_out_18), .data_out_19(data_out_19), .data_out_20(data_out_20),
    .data_out_21(data_out_21), .data_out_22(data_out_22), .data_out_23(data_out_23),
    .data_out_24(data_out_24),
    .valid_out_buf(valid_out_buf)
`ifdef CONV2_WIN_FRAME_DONE_EN
    , .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  // One clock; sample 1 time unit after the rising edge and log any window pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out_buf === 1'b1) begin
      wins.push_back(taps);
      win_cyc.push_back(cyc);
    end else if (taps !== last_taps) begin
      hold_viol++;
    end
    last_taps = taps;
`ifdef CONV2_WIN_FRAME_DONE_EN
    if (frame_done === 1'b1) fd_val.push_back(data_out_24);
`endif
  endtask

  task automatic clear_log();
    wins.delete();
    win_cyc.delete();
    fd_val.delete();
    hold_viol = 0;
  endtask

  // Pad so later indexed comparisons fail cleanly instead of reading past the end.
  task automatic pad_log(input int n);
    while (wins.size() < n) begin
      wins.push_back('x);
      win_cyc.push_back(-100);
    end
  endtask

  task automatic send(input logic [11:0] d, input int gap, output int acc);
    valid_in = 1'b1;
    data_in  = d;
    tick();
    acc = cyc;
    valid_in = 1'b0;
    data_in  = 12'hABC;
    repeat (gap) tick();
  endtask

  task automatic send_ramp(input int gap);
    int acc;
    for (int n = 0; n < 144; n++) begin
      send(12'(n), gap, acc);
      if (n == 52) acc52 = acc;
    end
  endtask

  function automatic win_t ramp_exp(input int k);
    win_t w;
    int rr, cc;
    rr = 4 + k / 8;
    cc = 4 + k % 8;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[r*5+c] = 12'((rr - 4 + r) * 12 + (cc - 4 + c));
    return w;
  endfunction

  function automatic win_t sign_exp(input int k);
    win_t w;
    int rr, cc, n;
    rr = 4 + k / 8;
    cc = 4 + k % 8;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        n = (rr - 4 + r) * 12 + (cc - 4 + c);
        w[r*5+c] = (n % 2 == 1) ? 12'h7FF : 12'h800;
      end
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (taps !== '0 || valid_out_buf !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: taps %h valid %b, required 0", taps, valid_out_buf);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (taps !== '0 || valid_out_buf !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: taps %h valid %b, required 0", taps, valid_out_buf);
    end
`ifdef CONV2_WIN_FRAME_DONE_EN
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b required 0", frame_done);
    end
`endif
  endtask

  task automatic test_ramp();
    clear_log();
    send_ramp(0);
    tick();
    tick();
    checks++;
    if (wins.size() != 64) begin
      errors++;
      $display("FAIL ramp_count: got %0d required 64", wins.size());
    end
    pad_log(64);
    checks++;
    if (win_cyc[0] != acc52 + 1) begin
      errors++;
      $display("FAIL ramp_latency: first pulse cycle %0d required %0d", win_cyc[0], acc52 + 1);
    end
    checks++;
    if (wins[0][0] !== 12'd0 || wins[0][4] !== 12'd4 || wins[0][20] !== 12'd48 ||
        wins[0][24] !== 12'd52) begin
      errors++;
      $display("FAIL ramp_first_win: got %0d %0d %0d %0d required 0 4 48 52",
               wins[0][0], wins[0][4], wins[0][20], wins[0][24]);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (wins[k] !== ramp_exp(k)) begin
        errors++;
        $display("FAIL ramp_win%0d: got %h required %h", k, wins[k], ramp_exp(k));
      end
    end
    // Row edge: window (4,11) then four skipped pixels (5,0)..(5,3) before (5,4).
    checks++;
    if (wins[7][0] !== 12'd7 || wins[7][24] !== 12'd59) begin
      errors++;
      $display("FAIL row_edge_last: got %0d..%0d required 7..59", wins[7][0], wins[7][24]);
    end
    checks++;
    if (win_cyc[8] - win_cyc[7] != 5) begin
      errors++;
      $display("FAIL row_edge_gap: got %0d cycles required 5", win_cyc[8] - win_cyc[7]);
    end
    checks++;
    if (wins[8][0] !== 12'd12) begin
      errors++;
      $display("FAIL row_edge_next: data_out_0 %0d required 12", wins[8][0]);
    end
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL ramp_hold: %0d tap changes without pulse, required 0", hold_viol);
    end
`ifdef CONV2_WIN_FRAME_DONE_EN
    checks++;
    if (fd_val.size() != 1) begin
      errors++;
      $display("FAIL ramp_frame_done: got %0d pulses required 1", fd_val.size());
    end
`endif
  endtask

  task automatic test_gaps();
    clear_log();
    send_ramp(3);
    repeat (3) tick();
    checks++;
    if (wins.size() != 64) begin
      errors++;
      $display("FAIL gaps_count: got %0d required 64", wins.size());
    end
    pad_log(64);
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (wins[k] !== ramp_exp(k)) begin
        errors++;
        $display("FAIL gaps_win%0d: got %h required %h", k, wins[k], ramp_exp(k));
      end
    end
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL gaps_hold: %0d tap changes without pulse, required 0", hold_viol);
    end
  endtask

  task automatic test_signs();
    int acc;
    clear_log();
    for (int n = 0; n < 144; n++) send((n % 2 == 1) ? 12'h7FF : 12'h800, 0, acc);
    tick();
    tick();
    checks++;
    if (wins.size() != 64) begin
      errors++;
      $display("FAIL signs_count: got %0d required 64", wins.size());
    end
    pad_log(64);
    checks++;
    if (wins[0][0] !== 12'h800 || wins[0][1] !== 12'h7FF) begin
      errors++;
      $display("FAIL signs_first: got %h %h required 800 7ff", wins[0][0], wins[0][1]);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (wins[k] !== sign_exp(k)) begin
        errors++;
        $display("FAIL signs_win%0d: got %h required %h", k, wins[k], sign_exp(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_ramp(0);
    send_ramp(0);
    tick();
    tick();
    checks++;
    if (wins.size() != 128) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 128", wins.size());
    end
    pad_log(128);
    checks++;
    if (wins[64][0] !== 12'd0 || wins[64][24] !== 12'd52) begin
      errors++;
      $display("FAIL b2b_frame2_first: got %0d %0d required 0 52", wins[64][0], wins[64][24]);
    end
    for (int k = 0; k < 128; k++) begin
      checks++;
      if (wins[k] !== ramp_exp(k % 64)) begin
        errors++;
        $display("FAIL b2b_win%0d: got %h required %h", k, wins[k], ramp_exp(k % 64));
      end
    end
`ifdef CONV2_WIN_FRAME_DONE_EN
    checks++;
    if (fd_val.size() != 2) begin
      errors++;
      $display("FAIL b2b_frame_done_count: got %0d required 2", fd_val.size());
    end
    for (int i = 0; i < fd_val.size(); i++) begin
      checks++;
      if (fd_val[i] !== 12'd143) begin
        errors++;
        $display("FAIL b2b_frame_done_tap%0d: got %0d required 143", i, fd_val[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int acc;
    int n_before;
    clear_log();
    for (int n = 0; n < 70; n++) send(12'(n), 0, acc);
    // Pixel 69 (row 5, col 9) has a window pending; reset must drop it.
    rst_n = 1'b0;
    #1;
    checks++;
    if (taps !== '0 || valid_out_buf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: taps %h valid %b, required 0", taps, valid_out_buf);
    end
    n_before = wins.size();
    tick();
    tick();
    checks++;
    if (wins.size() != n_before) begin
      errors++;
      $display("FAIL midreset_drop: got %0d pulses during reset required 0",
               wins.size() - n_before);
    end
    rst_n = 1'b1;
    clear_log();
    send_ramp(0);
    tick();
    tick();
    checks++;
    if (wins.size() != 64) begin
      errors++;
      $display("FAIL midreset_count: got %0d required 64", wins.size());
    end
    pad_log(64);
    checks++;
    if (win_cyc[0] != acc52 + 1 || wins[0][0] !== 12'd0) begin
      errors++;
      $display("FAIL midreset_first: cycle %0d tap0 %0d, required cycle %0d tap0 0",
               win_cyc[0], wins[0][0], acc52 + 1);
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (wins[k] !== ramp_exp(k)) begin
        errors++;
        $display("FAIL midreset_win%0d: got %h required %h", k, wins[k], ramp_exp(k));
      end
    end
  endtask

  initial begin
    last_taps = '0;
    test_reset();
    test_ramp();
    test_gaps();
    test_signs();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
